// File: rtl/z16_instr_loader_if.sv
// Byte-stream receive and instruction-memory write bundle for the Z16 instruction loader.
// The master side is the loader; the slave side is the byte source plus the memory write port.
interface z16_instr_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_wen;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_addr,
        output imem_data,
        output imem_wen
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_addr,
        input  imem_data,
        input  imem_wen
    );
endinterface

// File: rtl/z16_instr_loader.sv
// Z16 instruction loader: turns a length-prefixed byte stream into 16-bit imem writes and holds the CPU in reset meanwhile.
// Optional trailing XOR checksum byte enabled by defining Z16_LOADER_CHECKSUM_EN.
module z16_instr_loader #(
    parameter int MEM_WORDS = 256
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    z16_instr_loader_if.master bus,
    output logic               o_cpu_rst,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
`ifdef Z16_LOADER_CHECKSUM_EN
        ST_CHK     = 3'd5,
`endif
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    localparam logic [16:0] MEM_WORDS_C = 17'(MEM_WORDS);

`ifdef Z16_LOADER_CHECKSUM_EN
    localparam state_t FIN_ST = ST_CHK;
`else
    localparam state_t FIN_ST = ST_DONE;
`endif

    // Running checksum step: XOR-fold one received byte into the accumulator.
    function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // States in which a byte may be taken from the stream.
    function automatic logic rx_state(input state_t s);
        logic r;
        case (s)
            ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI: r = 1'b1;
`ifdef Z16_LOADER_CHECKSUM_EN
            ST_CHK:                                       r = 1'b1;
`endif
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

    state_t      state_r,   state_nx_s;
    logic [7:0]  len_lo_r,  len_lo_nx_s;
    logic [15:0] len_r,     len_nx_s;
    logic [15:0] idx_r,     idx_nx_s;
    logic [7:0]  lo_r,      lo_nx_s;
    logic [15:0] addr_r,    addr_nx_s;
    logic [15:0] data_r,    data_nx_s;
    logic        wen_r,     wen_nx_s;
    logic        rx_ready_r, rx_ready_nx_s;
    logic        cpu_rst_r, cpu_rst_nx_s;
    logic        busy_r,    busy_nx_s;
    logic        done_r,    done_nx_s;
    logic        error_r,   error_nx_s;
    logic        accept_s;
    logic [15:0] len_full_s;
`ifdef Z16_LOADER_CHECKSUM_EN
    logic [7:0]  chk_r,     chk_nx_s;
`endif

    assign accept_s   = bus.rx_valid & rx_ready_r;
    assign len_full_s = {bus.rx_data, len_lo_r};

    // Next-state, datapath and status decode; status flags follow directly from the next state.
    always_comb begin
        state_nx_s  = state_r;
        len_lo_nx_s = len_lo_r;
        len_nx_s    = len_r;
        idx_nx_s    = idx_r;
        lo_nx_s     = lo_r;
        addr_nx_s   = addr_r;
        data_nx_s   = data_r;
        wen_nx_s    = 1'b0;
`ifdef Z16_LOADER_CHECKSUM_EN
        chk_nx_s    = accept_s ? xor_acc(chk_r, bus.rx_data) : chk_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    state_nx_s = ST_LEN_LO;
                    idx_nx_s   = 16'd0;
`ifdef Z16_LOADER_CHECKSUM_EN
                    chk_nx_s   = 8'd0;
`endif
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_lo_nx_s = bus.rx_data;
                    state_nx_s  = ST_LEN_HI;
                end else begin
                    state_nx_s  = state_r;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_nx_s = len_full_s;
                    if ({1'b0, len_full_s} > MEM_WORDS_C) begin
                        state_nx_s = ST_ERR;
                    end else if (len_full_s == 16'd0) begin
                        state_nx_s = FIN_ST;
                    end else begin
                        state_nx_s = ST_DATA_LO;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_DATA_LO: begin
                if (accept_s) begin
                    lo_nx_s    = bus.rx_data;
                    state_nx_s = ST_DATA_HI;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_DATA_HI: begin
                if (accept_s) begin
                    wen_nx_s   = 1'b1;
                    addr_nx_s  = idx_r << 1;
                    data_nx_s  = {bus.rx_data, lo_r};
                    idx_nx_s   = idx_r + 16'd1;
                    state_nx_s = ((idx_r + 16'd1) == len_r) ? FIN_ST : ST_DATA_LO;
                end else begin
                    state_nx_s = state_r;
                end
            end
`ifdef Z16_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    state_nx_s = (bus.rx_data == chk_r) ? ST_DONE : ST_ERR;
                end else begin
                    state_nx_s = state_r;
                end
            end
`endif
            default: begin
                state_nx_s = ST_ERR;
            end
        endcase
        rx_ready_nx_s = rx_state(state_nx_s);
        busy_nx_s     = rx_state(state_nx_s);
        done_nx_s     = (state_nx_s == ST_DONE);
        error_nx_s    = (state_nx_s == ST_ERR);
        cpu_rst_nx_s  = (state_nx_s != ST_DONE);
    end

    // State and registered outputs; reset abandons any session in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            len_lo_r   <= 8'd0;
            len_r      <= 16'd0;
            idx_r      <= 16'd0;
            lo_r       <= 8'd0;
            addr_r     <= 16'd0;
            data_r     <= 16'd0;
            wen_r      <= 1'b0;
            rx_ready_r <= 1'b0;
            cpu_rst_r  <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
`ifdef Z16_LOADER_CHECKSUM_EN
            chk_r      <= 8'd0;
`endif
        end else begin
            state_r    <= state_nx_s;
            len_lo_r   <= len_lo_nx_s;
            len_r      <= len_nx_s;
            idx_r      <= idx_nx_s;
            lo_r       <= lo_nx_s;
            addr_r     <= addr_nx_s;
            data_r     <= data_nx_s;
            wen_r      <= wen_nx_s;
            rx_ready_r <= rx_ready_nx_s;
            cpu_rst_r  <= cpu_rst_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            error_r    <= error_nx_s;
`ifdef Z16_LOADER_CHECKSUM_EN
            chk_r      <= chk_nx_s;
`endif
        end
    end

    assign bus.rx_ready  = rx_ready_r;
    assign bus.imem_addr = addr_r;
    assign bus.imem_data = data_r;
    assign bus.imem_wen  = wen_r;
    assign o_cpu_rst     = cpu_rst_r;
    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_error       = error_r;

endmodule

// File: tb/tb_z16_instr_loader.sv
// Scoreboard bench for z16_instr_loader: expected imem writes are queued as images are built and popped on each strobe.
// Follows Z16_LOADER_CHECKSUM_EN so the same bench covers both builds.
module tb_z16_instr_loader;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_start = 1'b0;
    logic o_cpu_rst, o_busy, o_done, o_error;

    z16_instr_loader_if bus ();

    z16_instr_loader #(.MEM_WORDS(256)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .bus       (bus),
        .o_cpu_rst (o_cpu_rst),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error)
    );

    always #5 i_clk = ~i_clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] exp_q[$];
    logic [15:0] wtab[256];
    logic [7:0]  img[$];
    logic        prev_wen = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must be expected, single-cycle, and match the queue head.
    always @(negedge i_clk) begin
        if (bus.imem_wen === 1'b1) begin
            check_val("wen_expected", 32'(exp_q.size() != 0), 32'd1);
            check_val("wen_pulse", 32'(prev_wen), 32'd0);
            if (exp_q.size() != 0) begin
                check_val("imem_write", {bus.imem_addr, bus.imem_data}, exp_q.pop_front());
            end
        end
        prev_wen = (bus.imem_wen === 1'b1);
    end

    task automatic build(input logic [15:0] len, input bit bad_chk);
        logic [7:0] x;
        img = {};
        img.push_back(len[7:0]);
        img.push_back(len[15:8]);
        if ({1'b0, len} <= 17'd256) begin
            for (int i = 0; i < int'(len); i++) begin
                img.push_back(wtab[i][7:0]);
                img.push_back(wtab[i][15:8]);
                exp_q.push_back({16'(2 * i), wtab[i]});
            end
`ifdef Z16_LOADER_CHECKSUM_EN
            x = 8'd0;
            foreach (img[i]) x = x ^ img[i];
            img.push_back(bad_chk ? 8'hFF : x);
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse);
        bit rdy;
        int n;
        if (gap) begin
            bus.rx_valid = 1'b0;
            i_start      = pulse;
            @(negedge i_clk);
            i_start      = 1'b0;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 50) begin
            rdy = bus.rx_ready;
            @(negedge i_clk);
            n++;
        end
        if (!rdy) check_val("rx_stall", 32'(rdy), 32'd1);
    endtask

    task automatic drive(input bit gaps, input int pulse_at);
        foreach (img[i]) send_byte(img[i], gaps, (i == pulse_at));
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_start(input string tag);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check_val({tag, "_busy"},     32'(o_busy),       32'd1);
        check_val({tag, "_cpurst"},   32'(o_cpu_rst),    32'd1);
        check_val({tag, "_clr"},      {30'd0, o_done, o_error}, 32'd0);
        check_val({tag, "_rxready"},  32'(bus.rx_ready), 32'd1);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(o_done || o_error) && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check_val({tag, "_end_timeout"}, 32'(n < 20), 32'd1);
        @(negedge i_clk);
        check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic finish_ok(input string tag);
        wait_end(tag);
        check_val({tag, "_done"},    32'(o_done),       32'd1);
        check_val({tag, "_error"},   32'(o_error),      32'd0);
        check_val({tag, "_cpurst"},  32'(o_cpu_rst),    32'd0);
        check_val({tag, "_busy"},    32'(o_busy),       32'd0);
        check_val({tag, "_rxready"}, 32'(bus.rx_ready), 32'd0);
    endtask

    task automatic finish_err(input string tag);
        wait_end(tag);
        check_val({tag, "_error"},   32'(o_error),      32'd1);
        check_val({tag, "_done"},    32'(o_done),       32'd0);
        check_val({tag, "_cpurst"},  32'(o_cpu_rst),    32'd1);
        check_val({tag, "_busy"},    32'(o_busy),       32'd0);
        check_val({tag, "_rxready"}, 32'(bus.rx_ready), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_cpurst"},  32'(o_cpu_rst), 32'd1);
        check_val({tag, "_status"},  {29'd0, o_busy, o_done, o_error}, 32'd0);
        check_val({tag, "_bus"},     {30'd0, bus.rx_ready, bus.imem_wen}, 32'd0);
        check_val({tag, "_addrdat"}, {bus.imem_addr, bus.imem_data}, 32'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        wtab[0] = 16'h1234;
        wtab[1] = 16'h5678;
        for (int i = 2; i < 256; i++) wtab[i] = 16'(i * 16'h0101) ^ 16'hA5C3;

        repeat (2) @(negedge i_clk);
        check_reset("por");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Normal two-word image
        do_start("t1");
        build(16'd2, 1'b0);
        drive(1'b0, -1);
        finish_ok("t1");

        // Empty image
        do_start("t2");
        build(16'd0, 1'b0);
        drive(1'b0, -1);
        finish_ok("t2");

        // Oversize length
        do_start("t3");
        build(16'd257, 1'b0);
        drive(1'b0, -1);
        finish_err("t3");

        // Gaps between bytes with a stray start pulse mid-load
        do_start("t4");
        build(16'd2, 1'b0);
        drive(1'b1, 3);
        finish_ok("t4");

        // Reset in the middle of a load
        do_start("t5");
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        bus.rx_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_reset("t5_rst");
        repeat (3) @(negedge i_clk);
        check_reset("t5_hold");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        do_start("t5b");
        build(16'd2, 1'b0);
        drive(1'b0, -1);
        finish_ok("t5b");

        // Full-depth image, last address 0x01FE
        do_start("tmax");
        build(16'd256, 1'b0);
        drive(1'b0, -1);
        finish_ok("tmax");

`ifdef Z16_LOADER_CHECKSUM_EN
        // Bad checksum: words still written, session ends in error
        do_start("t6");
        build(16'd2, 1'b1);
        drive(1'b0, -1);
        finish_err("t6");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
